coin_credit_accumulator: RTL and testbench
==========================================

Name: coin_credit_accumulator

Overview:
- Upstream front-end of the vending machine core.
- Converts user coin insertions (coin_in value plus currency_type) into a single base-unit credit for the identified client session.
- On confirm, hands the accumulated credit and the latched client_id to the vending core through a valid/ready handshake.
- Refunds the credit if the session is abandoned before confirm.

Parameters:
- RATE_0, 1, base units per coin unit for currency_type 0
- RATE_1, 90, base units per coin unit for currency_type 1
- RATE_2, 100, base units per coin unit for currency_type 2
- MAX_CREDIT, 100000, credit ceiling in base units; a coin that would exceed it is rejected

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  client identified; level, held high for the whole session
- client_id  input  9  client identifier, sampled on session start
- coin_in  input  6  face value of inserted coin
- currency_type  input  2  0/1/2 valid, 3 invalid
- coin_insert  input  1  single-cycle strobe qualifying coin_in/currency_type
- confirm  input  1  single-cycle strobe: user ends insertion
- credit_ready  input  1  vending core accepts the handoff
- credit_valid  output  1  handoff pending
- credit_out  output  32  running credit; handoff value while credit_valid
- credit_client_id  output  9  latched client_id
- session_active  output  1  high in COLLECT
- coin_reject  output  1  one-cycle pulse: the last coin was returned, not credited
- refund_valid  output  1  one-cycle pulse on session abort
- refund_amount  output  32  credit returned; valid with refund_valid

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; internal credit 0.
- States:
  - IDLE -> COLLECT when id_valid=1. client_id is latched into credit_client_id on this edge; credit is cleared.
  - COLLECT -> HANDOFF on confirm=1 while credit (including any coin accepted that same cycle) is nonzero. confirm is ignored when credit is 0.
  - COLLECT -> IDLE when id_valid=0 (abort).
  - HANDOFF -> IDLE on the cycle credit_valid & credit_ready are both high. credit is cleared on exit.
- Coin arithmetic:
  - value = coin_in * RATE_n in 32-bit unsigned.
  - Accepted iff all hold: state is COLLECT, currency_type != 3, coin_in != 0, id_valid=1, and credit + value <= MAX_CREDIT.
  - Accepted coin: credit_out updates on the next rising edge (1-cycle latency).
  - Rejected coin: coin_reject=1 for exactly the next cycle; credit unchanged.
- coin_insert outside COLLECT (IDLE or HANDOFF) is rejected.
- coin_insert and confirm in the same COLLECT cycle: the coin is evaluated first. If accepted, it is included in the handoff value.
- Abort:
  - id_valid low in COLLECT: refund_valid=1 and refund_amount=credit for one cycle, next edge.
  - credit_out is cleared to 0 and credit_client_id is held.
  - If credit is 0 at abort, refund_valid still pulses with amount 0.
- Abort with a simultaneous coin_insert: the coin is rejected (coin_reject pulses) and excluded from the refund.
- HANDOFF:
  - credit_valid is asserted the cycle after the confirm edge and held until accepted.
  - credit_out and credit_client_id are stable while credit_valid is high.
  - id_valid drop is ignored (transaction committed).
  - confirm is ignored.
- session_active = (state == COLLECT), registered.
- Reset mid-HANDOFF or mid-COLLECT: immediate return to reset values; no refund pulse.

Optional Feature:
- Macro COIN_COUNT_EN.
- Defined:
  - Adds output coin_count [7:0]: number of accepted coins in the current session.
  - Cleared on IDLE->COLLECT entry and on reset.
  - Increments 1 cycle after each accepted coin; saturates at 255.
  - Held through HANDOFF; cleared to 0 on return to IDLE.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- id_valid=1, client_id=9'd37; coins (5,type0),(2,type1),(1,type2); confirm; credit_ready=1 two cycles after credit_valid -> credit_out=5,185,285 after each coin; credit_valid held 2 cycles with 285, credit_client_id=37; then IDLE, credit_out=0.
- COLLECT, coin (10,type3), then (0,type0) -> coin_reject pulses once per coin, credit stays 0; confirm ignored, credit_valid stays 0.
- MAX_CREDIT=100000, credit 99950; coin (1,type2) -> rejected, credit 99950; coin (50,type0) -> accepted, credit 100000.
- credit 180; id_valid drops in the same cycle as coin (3,type0) -> coin_reject=1 and refund_valid=1 with refund_amount=180 next cycle; state IDLE.
- credit 90; coin_insert (1,type0) and confirm in the same cycle -> credit_valid with credit_out=91; hold credit_ready=0 for 5 cycles while toggling id_valid and inserting a coin -> values stable, coin rejected; rst_n low mid-HANDOFF -> all outputs 0 asynchronously.
- With COIN_COUNT_EN: 3 accepted coins plus 1 rejected -> coin_count=3 at handoff; 0 after return to IDLE.

Source files
------------

// File: rtl/coin_credit_accumulator.sv
// Coin credit accumulator: converts coins to base-unit credit per client session and hands it to the vending core.
// Optional `COIN_COUNT_EN adds coin_count[7:0], the number of accepted coins in the session.
module coin_credit_accumulator #(
  parameter int unsigned RATE_0     = 1,
  parameter int unsigned RATE_1     = 90,
  parameter int unsigned RATE_2     = 100,
  parameter int unsigned MAX_CREDIT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [8:0]  client_id,
  input  logic [5:0]  coin_in,
  input  logic [1:0]  currency_type,
  input  logic        coin_insert,
  input  logic        confirm,
  input  logic        credit_ready,
  output logic        credit_valid,
  output logic [31:0] credit_out,
  output logic [8:0]  credit_client_id,
  output logic        session_active,
  output logic        coin_reject,
  output logic        refund_valid,
  output logic [31:0] refund_amount
`ifdef COIN_COUNT_EN
  ,
  output logic [7:0]  coin_count
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, HANDOFF = 2'd2} state_t;

  localparam logic [31:0] R0     = 32'(RATE_0);
  localparam logic [31:0] R1     = 32'(RATE_1);
  localparam logic [31:0] R2     = 32'(RATE_2);
  localparam logic [32:0] MAX_CR = 33'(MAX_CREDIT);

  state_t      state_q, state_d;
  logic [31:0] credit_q, credit_d;
  logic [8:0]  client_q, client_d;
  logic        cv_q, cv_d;
  logic        active_q, active_d;
  logic        reject_q, reject_d;
  logic        refund_v_q, refund_v_d;
  logic [31:0] refund_a_q, refund_a_d;
  logic [7:0]  count_q, count_d;

  logic [31:0] rate;
  logic [31:0] coin_value;
  logic [32:0] sum;
  logic        coin_ok;
  logic        accept;
  logic [31:0] credit_next;

  // Coin evaluation; the sum is one bit wider so the ceiling compare cannot wrap.
  always_comb begin
    rate = '0;
    case (currency_type)
      2'd0:    rate = R0;
      2'd1:    rate = R1;
      2'd2:    rate = R2;
      default: rate = '0;
    endcase
    coin_value  = 32'(coin_in) * rate;
    sum         = {1'b0, credit_q} + {1'b0, coin_value};
    coin_ok     = (state_q == COLLECT) && (currency_type != 2'd3) && (coin_in != 6'd0) &&
                  id_valid && (sum <= MAX_CR);
    accept      = coin_insert && coin_ok;
    credit_next = accept ? sum[31:0] : credit_q;
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    client_d   = client_q;
    cv_d       = cv_q;
    reject_d   = coin_insert && !coin_ok;
    refund_v_d = 1'b0;
    refund_a_d = '0;
    count_d    = count_q;
    case (state_q)
      IDLE: begin
        if (id_valid) begin
          state_d  = COLLECT;
          client_d = client_id;
          credit_d = '0;
          count_d  = '0;
        end
      end
      COLLECT: begin
        if (!id_valid) begin
          // Abort: any coin this cycle is already rejected via coin_ok, so it never reaches the refund.
          state_d    = IDLE;
          refund_v_d = 1'b1;
          refund_a_d = credit_q;
          credit_d   = '0;
          count_d    = '0;
        end else begin
          credit_d = credit_next;
          if (accept && count_q != 8'hFF) count_d = count_q + 8'd1;
          if (confirm && credit_next != '0) begin
            state_d = HANDOFF;
            cv_d    = 1'b1;
          end
        end
      end
      HANDOFF: begin
        if (cv_q && credit_ready) begin
          state_d  = IDLE;
          cv_d     = 1'b0;
          credit_d = '0;
          count_d  = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        cv_d     = 1'b0;
        credit_d = '0;
        count_d  = '0;
      end
    endcase
    active_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      client_q   <= '0;
      cv_q       <= 1'b0;
      active_q   <= 1'b0;
      reject_q   <= 1'b0;
      refund_v_q <= 1'b0;
      refund_a_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      client_q   <= client_d;
      cv_q       <= cv_d;
      active_q   <= active_d;
      reject_q   <= reject_d;
      refund_v_q <= refund_v_d;
      refund_a_q <= refund_a_d;
      count_q    <= count_d;
    end
  end

  assign credit_valid     = cv_q;
  assign credit_out       = credit_q;
  assign credit_client_id = client_q;
  assign session_active   = active_q;
  assign coin_reject      = reject_q;
  assign refund_valid     = refund_v_q;
  assign refund_amount    = refund_a_q;

`ifdef COIN_COUNT_EN
  assign coin_count = count_q;
`else
  logic unused_count;
  assign unused_count = ^count_q;
`endif

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Directed bench for coin_credit_accumulator: a cycle table plus hand sequences for ceiling, reset and coin count.
module tb_coin_credit_accumulator;

  logic        clk, rst_n;
  logic        id_valid, coin_insert, confirm, credit_ready;
  logic [8:0]  client_id;
  logic [5:0]  coin_in;
  logic [1:0]  currency_type;
  logic        credit_valid, session_active, coin_reject, refund_valid;
  logic [31:0] credit_out, refund_amount;
  logic [8:0]  credit_client_id;
`ifdef COIN_COUNT_EN
  logic [7:0]  coin_count;
`endif

  int checks = 0;
  int failures = 0;

  coin_credit_accumulator dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .client_id(client_id),
    .coin_in(coin_in), .currency_type(currency_type), .coin_insert(coin_insert),
    .confirm(confirm), .credit_ready(credit_ready), .credit_valid(credit_valid),
    .credit_out(credit_out), .credit_client_id(credit_client_id),
    .session_active(session_active), .coin_reject(coin_reject),
    .refund_valid(refund_valid), .refund_amount(refund_amount)
`ifdef COIN_COUNT_EN
    , .coin_count(coin_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [8:0]  cid;
    logic [5:0]  coin;
    logic [1:0]  cur;
    logic        ins, conf, rdy;
    logic        cv;
    logic [31:0] cout;
    logic [8:0]  ccid;
    logic        sa, rej, rfv;
    logic [31:0] rfa;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic iv, input logic [8:0] cid, input logic [5:0] coin,
                              input logic [1:0] cur, input logic ins, input logic conf,
                              input logic rdy, input logic cv, input logic [31:0] cout,
                              input logic [8:0] ccid, input logic sa, input logic rej,
                              input logic rfv, input logic [31:0] rfa);
    vec_t v;
    v.iv = iv; v.cid = cid; v.coin = coin; v.cur = cur; v.ins = ins; v.conf = conf; v.rdy = rdy;
    v.cv = cv; v.cout = cout; v.ccid = ccid; v.sa = sa; v.rej = rej; v.rfv = rfv; v.rfa = rfa;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [8:0] cid, input logic [5:0] coin,
                      input logic [1:0] cur, input logic ins, input logic conf, input logic rdy);
    @(negedge clk);
    id_valid = iv; client_id = cid; coin_in = coin; currency_type = cur;
    coin_insert = ins; confirm = conf; credit_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic cv, input logic [31:0] cout,
                         input logic [8:0] ccid, input logic sa, input logic rej,
                         input logic rfv, input logic [31:0] rfa);
    chk({tag, " credit_valid"}, 32'(credit_valid), 32'(cv));
    chk({tag, " credit_out"}, credit_out, cout);
    chk({tag, " client_id"}, 32'(credit_client_id), 32'(ccid));
    chk({tag, " session_active"}, 32'(session_active), 32'(sa));
    chk({tag, " coin_reject"}, 32'(coin_reject), 32'(rej));
    chk({tag, " refund_valid"}, 32'(refund_valid), 32'(rfv));
    chk({tag, " refund_amount"}, refund_amount, rfa);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; id_valid = 0; client_id = '0; coin_in = '0; currency_type = '0;
    coin_insert = 0; confirm = 0; credit_ready = 0;

    //   iv cid  coin cur ins cf rdy | cv cout   ccid sa rej rfv rfa
    add(1, 37,  0, 0, 0, 0, 0,   0, 0,   37, 1, 0, 0, 0);
    add(1, 0,   5, 0, 1, 0, 0,   0, 5,   37, 1, 0, 0, 0);
    add(1, 0,   2, 1, 1, 0, 0,   0, 185, 37, 1, 0, 0, 0);
    add(1, 0,   1, 2, 1, 0, 0,   0, 285, 37, 1, 0, 0, 0);
    add(1, 0,   0, 0, 0, 1, 0,   1, 285, 37, 0, 0, 0, 0);
    add(1, 0,   0, 0, 0, 0, 0,   1, 285, 37, 0, 0, 0, 0);
    add(0, 0,   0, 0, 0, 0, 1,   0, 0,   37, 0, 0, 0, 0);
    // invalid currency, zero coin, confirm with zero credit
    add(1, 5,   0, 0, 0, 0, 0,   0, 0,   5,  1, 0, 0, 0);
    add(1, 0,  10, 3, 1, 0, 0,   0, 0,   5,  1, 1, 0, 0);
    add(1, 0,   0, 0, 0, 0, 0,   0, 0,   5,  1, 0, 0, 0);
    add(1, 0,   0, 0, 1, 0, 0,   0, 0,   5,  1, 1, 0, 0);
    add(1, 0,   0, 0, 0, 1, 0,   0, 0,   5,  1, 0, 0, 0);
    add(1, 0,   0, 0, 0, 0, 0,   0, 0,   5,  1, 0, 0, 0);
    // abort with simultaneous coin, coin in IDLE, abort with zero credit
    add(1, 0,   2, 1, 1, 0, 0,   0, 180, 5,  1, 0, 0, 0);
    add(0, 0,   3, 0, 1, 0, 0,   0, 0,   5,  0, 1, 1, 180);
    add(0, 0,   5, 0, 1, 0, 0,   0, 0,   5,  0, 1, 0, 0);
    add(1, 7,   0, 0, 0, 0, 0,   0, 0,   7,  1, 0, 0, 0);
    add(0, 0,   0, 0, 0, 0, 0,   0, 0,   7,  0, 0, 1, 0);
    // coin with confirm, then HANDOFF held while id_valid toggles
    add(1, 300, 0, 0, 0, 0, 0,   0, 0,   300, 1, 0, 0, 0);
    add(1, 0,   1, 1, 1, 0, 0,   0, 90,  300, 1, 0, 0, 0);
    add(1, 0,   1, 0, 1, 1, 0,   1, 91,  300, 0, 0, 0, 0);
    add(0, 0,   0, 0, 0, 0, 0,   1, 91,  300, 0, 0, 0, 0);
    add(1, 0,   1, 2, 1, 0, 0,   1, 91,  300, 0, 1, 0, 0);
    add(0, 0,   0, 0, 0, 1, 0,   1, 91,  300, 0, 0, 0, 0);
    add(1, 0,   0, 0, 0, 0, 0,   1, 91,  300, 0, 0, 0, 0);
    add(0, 0,   0, 0, 0, 0, 0,   1, 91,  300, 0, 0, 0, 0);

    #2;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].iv, tbl[i].cid, tbl[i].coin, tbl[i].cur, tbl[i].ins, tbl[i].conf, tbl[i].rdy);
      chk_all($sformatf("row%0d", i), tbl[i].cv, tbl[i].cout, tbl[i].ccid, tbl[i].sa,
              tbl[i].rej, tbl[i].rfv, tbl[i].rfa);
    end

    // Asynchronous reset while HANDOFF is pending
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    id_valid = 0; coin_insert = 0; confirm = 0; credit_ready = 0;
    rst_n = 1'b1;

    // Credit ceiling: build 99950 = 15*6300 + 5400 + 50
    step(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(1, 0, 63, 2, 1, 0, 0);
    chk("max_build", credit_out, 94500);
    step(1, 0, 54, 2, 1, 0, 0);
    step(1, 0, 50, 0, 1, 0, 0);
    chk("max_99950", credit_out, 99950);
    step(1, 0, 1, 2, 1, 0, 0);
    chk("max_over_rej", 32'(coin_reject), 1);
    chk("max_over_credit", credit_out, 99950);
    step(1, 0, 50, 0, 1, 0, 0);
    chk("max_exact_rej", 32'(coin_reject), 0);
    chk("max_exact_credit", credit_out, 100000);
    step(1, 0, 0, 0, 0, 1, 1);
    chk("max_cv", 32'(credit_valid), 1);
    chk("max_handoff_val", credit_out, 100000);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("max_done_cv", 32'(credit_valid), 0);
    chk("max_done_credit", credit_out, 0);

`ifdef COIN_COUNT_EN
    step(1, 2, 0, 0, 0, 0, 0);
    chk("cnt_entry", 32'(coin_count), 0);
    step(1, 0, 1, 0, 1, 0, 0);
    step(1, 0, 2, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 3, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("cnt_handoff", 32'(coin_count), 3);
    chk("cnt_handoff_credit", credit_out, 6);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("cnt_idle", 32'(coin_count), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
